// File: rtl/axisim_pkg.sv
// Shared constants, lane FSM encoding and port-mapping helper for the
// NetFPGA-1G-CML system-shell simulation model.
package axisim_pkg;

  localparam int NUM_PORTS          = 4;
  localparam int NIBBLE_W           = 4;
  localparam int DEF_PHY_RST_CYCLES = 16;
  localparam int DEF_MDC_DIV        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } lane_state_t;

  // Pairs are (0,1) and (2,3). The map is its own inverse, so the same call
  // yields either the destination of a source or the source of a destination.
  function automatic int port_map(input int src, input bit swap_pairs);
    return swap_pairs ? (src ^ 1) : src;
  endfunction

endpackage

// File: rtl/axisim_lane_if.sv
// One RGMII-style forwarding lane: receive nibble in, transmit nibble out,
// plus the lane FSM state for observation.
interface axisim_lane_if;
  import axisim_pkg::*;

  // rx_ctl / tx_ctl qualify rxd / txd as valid on every cycle they are high.
  // There is no ready: the lane never backpressures, so valid data is
  // consumed on the same edge it is presented.
  logic [NIBBLE_W-1:0] rxd;
  logic                rx_ctl;
  logic [NIBBLE_W-1:0] txd;
  logic                tx_ctl;
  lane_state_t         state;

  modport master (output rxd, rx_ctl, input txd, tx_ctl, state);
  modport slave  (input rxd, rx_ctl, output txd, tx_ctl, state);

endinterface

// File: rtl/axisim_fwd_lane.sv
// Two-stage nibble forwarding lane with frame-boundary gating: a frame passes
// only if forwarding was enabled on the cycle it started in stage 1.
module axisim_fwd_lane
  import axisim_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          fwd_en,
  axisim_lane_if.slave  lane
);

  logic [NIBBLE_W-1:0] s1_rxd;
  logic                s1_ctl;
  lane_state_t         state_q;
  logic                pass_now;

  // A new frame in IDLE is accepted only with forwarding enabled; once in
  // PASS, losing fwd_en drops the rest of the frame.
  assign pass_now = s1_ctl && fwd_en && (state_q != ST_DROP);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rxd      <= '0;
      s1_ctl      <= 1'b0;
      state_q     <= ST_IDLE;
      lane.txd    <= '0;
      lane.tx_ctl <= 1'b0;
    end else begin
      s1_rxd      <= lane.rxd;
      s1_ctl      <= lane.rx_ctl;
      lane.tx_ctl <= pass_now;
      lane.txd    <= pass_now ? s1_rxd : '0;
      if (!s1_ctl)
        state_q <= ST_IDLE;
      else if (pass_now)
        state_q <= ST_PASS;
      else
        state_q <= ST_DROP;
    end
  end

  assign lane.state = state_q;

endmodule

// File: rtl/system_axi_sim.sv
// Cycle-exact simulation shell of the reference-router board: PHY reset
// sequencing, gated nibble forwarding, MDC, UART echo and inert PCIe pins.
module system_axi_sim
  import axisim_pkg::*;
#(
  parameter int PHY_RST_CYCLES = DEF_PHY_RST_CYCLES,
  parameter int MDC_DIV        = DEF_MDC_DIV,
  parameter int SWAP_PAIRS     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  output logic                uart_tx,
  input  logic [NIBBLE_W-1:0] rgmii_rxd_1,
  input  logic [NIBBLE_W-1:0] rgmii_rxd_2,
  input  logic [NIBBLE_W-1:0] rgmii_rxd_3,
  input  logic [NIBBLE_W-1:0] rgmii_rxd_4,
  input  logic                rgmii_rx_ctl_1,
  input  logic                rgmii_rx_ctl_2,
  input  logic                rgmii_rx_ctl_3,
  input  logic                rgmii_rx_ctl_4,
  input  logic                rgmii_rxc_1,
  input  logic                rgmii_rxc_2,
  input  logic                rgmii_rxc_3,
  input  logic                rgmii_rxc_4,
  output logic [NIBBLE_W-1:0] rgmii_txd_1,
  output logic [NIBBLE_W-1:0] rgmii_txd_2,
  output logic [NIBBLE_W-1:0] rgmii_txd_3,
  output logic [NIBBLE_W-1:0] rgmii_txd_4,
  output logic                rgmii_tx_ctl_1,
  output logic                rgmii_tx_ctl_2,
  output logic                rgmii_tx_ctl_3,
  output logic                rgmii_tx_ctl_4,
  output logic                rgmii_txc_1,
  output logic                rgmii_txc_2,
  output logic                rgmii_txc_3,
  output logic                rgmii_txc_4,
  output logic                mdc,
  output logic                mdio,
  output logic [3:0]          phy_rstn,
  input  logic                dma_0_pci_exp_0_rxp_pin,
  input  logic                dma_0_pci_exp_0_rxn_pin,
  input  logic                dma_0_pci_exp_1_rxp_pin,
  input  logic                dma_0_pci_exp_1_rxn_pin,
  input  logic                dma_0_pci_exp_2_rxp_pin,
  input  logic                dma_0_pci_exp_2_rxn_pin,
  input  logic                dma_0_pci_exp_3_rxp_pin,
  input  logic                dma_0_pci_exp_3_rxn_pin,
  output logic                dma_0_pci_exp_0_txp_pin,
  output logic                dma_0_pci_exp_0_txn_pin,
  output logic                dma_0_pci_exp_1_txp_pin,
  output logic                dma_0_pci_exp_1_txn_pin,
  output logic                dma_0_pci_exp_2_txp_pin,
  output logic                dma_0_pci_exp_2_txn_pin,
  output logic                dma_0_pci_exp_3_txp_pin,
  output logic                dma_0_pci_exp_3_txn_pin,
  input  logic                dma_0_pcie_clk_p_pin,
  input  logic                dma_0_pcie_clk_n_pin,
  input  logic                util_ds_buf_0_IBUF_DS_P_pin
);

  localparam int CW = (PHY_RST_CYCLES > 0) ? $clog2(PHY_RST_CYCLES + 1) : 1;
  localparam int MW = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam bit SWAP = (SWAP_PAIRS != 0);
  localparam int SRC_1 = port_map(0, SWAP);
  localparam int SRC_2 = port_map(1, SWAP);
  localparam int SRC_3 = port_map(2, SWAP);
  localparam int SRC_4 = port_map(3, SWAP);

  logic [CW-1:0] phy_cnt;
  logic [MW-1:0] mdc_cnt;
  logic          uart_s1;
  logic          uart_s2;
  logic          txc_q;
  logic          fwd_en;

  logic [NIBBLE_W-1:0] rxd_a    [NUM_PORTS];
  logic                rx_ctl_a [NUM_PORTS];
  logic [NIBBLE_W-1:0] txd_l    [NUM_PORTS];
  logic                tx_ctl_l [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      phy_cnt  <= '0;
      phy_rstn <= 4'b0000;
      mdc_cnt  <= '0;
      mdc      <= 1'b0;
      uart_s1  <= 1'b1;
      uart_s2  <= 1'b1;
      txc_q    <= 1'b0;
    end else begin
      if (phy_cnt != CW'(PHY_RST_CYCLES))
        phy_cnt <= phy_cnt + CW'(1);
      phy_rstn <= {4{phy_cnt == CW'(PHY_RST_CYCLES)}};
      if (mdc_cnt == MW'(MDC_DIV - 1)) begin
        mdc_cnt <= '0;
        mdc     <= ~mdc;
      end else begin
        mdc_cnt <= mdc_cnt + MW'(1);
      end
      uart_s1 <= uart_rx;
      uart_s2 <= uart_s1;
      txc_q   <= ~txc_q;
    end
  end

  assign fwd_en  = &phy_rstn;
  assign uart_tx = uart_s2;
  assign mdio    = 1'b1;

  assign rxd_a[0] = rgmii_rxd_1;  assign rx_ctl_a[0] = rgmii_rx_ctl_1;
  assign rxd_a[1] = rgmii_rxd_2;  assign rx_ctl_a[1] = rgmii_rx_ctl_2;
  assign rxd_a[2] = rgmii_rxd_3;  assign rx_ctl_a[2] = rgmii_rx_ctl_3;
  assign rxd_a[3] = rgmii_rxd_4;  assign rx_ctl_a[3] = rgmii_rx_ctl_4;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
    axisim_lane_if lif ();
    lane_state_t   unused_state;

    assign lif.rxd      = rxd_a[k];
    assign lif.rx_ctl   = rx_ctl_a[k];
    assign txd_l[k]     = lif.txd;
    assign tx_ctl_l[k]  = lif.tx_ctl;
    assign unused_state = lif.state;

    axisim_fwd_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .fwd_en (fwd_en),
      .lane   (lif)
    );
  end

  // Each tx port is fed by the lane whose source maps onto it.
  assign rgmii_txd_1 = txd_l[SRC_1];  assign rgmii_tx_ctl_1 = tx_ctl_l[SRC_1];
  assign rgmii_txd_2 = txd_l[SRC_2];  assign rgmii_tx_ctl_2 = tx_ctl_l[SRC_2];
  assign rgmii_txd_3 = txd_l[SRC_3];  assign rgmii_tx_ctl_3 = tx_ctl_l[SRC_3];
  assign rgmii_txd_4 = txd_l[SRC_4];  assign rgmii_tx_ctl_4 = tx_ctl_l[SRC_4];

  assign rgmii_txc_1 = txc_q;
  assign rgmii_txc_2 = txc_q;
  assign rgmii_txc_3 = txc_q;
  assign rgmii_txc_4 = txc_q;

  assign dma_0_pci_exp_0_txp_pin = 1'b0;  assign dma_0_pci_exp_0_txn_pin = 1'b1;
  assign dma_0_pci_exp_1_txp_pin = 1'b0;  assign dma_0_pci_exp_1_txn_pin = 1'b1;
  assign dma_0_pci_exp_2_txp_pin = 1'b0;  assign dma_0_pci_exp_2_txn_pin = 1'b1;
  assign dma_0_pci_exp_3_txp_pin = 1'b0;  assign dma_0_pci_exp_3_txn_pin = 1'b1;

  logic unused_pins;
  assign unused_pins = ^{rgmii_rxc_1, rgmii_rxc_2, rgmii_rxc_3, rgmii_rxc_4,
                         dma_0_pci_exp_0_rxp_pin, dma_0_pci_exp_0_rxn_pin,
                         dma_0_pci_exp_1_rxp_pin, dma_0_pci_exp_1_rxn_pin,
                         dma_0_pci_exp_2_rxp_pin, dma_0_pci_exp_2_rxn_pin,
                         dma_0_pci_exp_3_rxp_pin, dma_0_pci_exp_3_rxn_pin,
                         dma_0_pcie_clk_p_pin, dma_0_pcie_clk_n_pin,
                         util_ds_buf_0_IBUF_DS_P_pin};

endmodule

// File: tb/tb_system_axi_sim.sv
// Directed bench for system_axi_sim at default parameters (16, 4, swapped pairs).
module tb_system_axi_sim;
  import axisim_pkg::*;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       uart_rx = 1'b1;
  wire        uart_tx;
  wire        mdc;
  wire        mdio;
  wire  [3:0] phy_rstn;
  wire        txc1, txc2, txc3, txc4;
  wire  [3:0] txp;
  wire  [3:0] txn;

  axisim_lane_if p1 ();
  axisim_lane_if p2 ();
  axisim_lane_if p3 ();
  axisim_lane_if p4 ();

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wire [4:0] tx1     = {p1.tx_ctl, p1.txd};
  wire [4:0] tx2     = {p2.tx_ctl, p2.txd};
  wire [4:0] tx3     = {p3.tx_ctl, p3.txd};
  wire [4:0] tx4     = {p4.tx_ctl, p4.txd};
  wire [3:0] txc_all = {txc4, txc3, txc2, txc1};
  wire [7:0] pcie_tx = {txp, txn};

  system_axi_sim dut (
    .clk                         (clk),
    .reset                       (reset),
    .uart_rx                     (uart_rx),
    .uart_tx                     (uart_tx),
    .rgmii_rxd_1                 (p1.rxd),
    .rgmii_rxd_2                 (p2.rxd),
    .rgmii_rxd_3                 (p3.rxd),
    .rgmii_rxd_4                 (p4.rxd),
    .rgmii_rx_ctl_1              (p1.rx_ctl),
    .rgmii_rx_ctl_2              (p2.rx_ctl),
    .rgmii_rx_ctl_3              (p3.rx_ctl),
    .rgmii_rx_ctl_4              (p4.rx_ctl),
    .rgmii_rxc_1                 (1'b0),
    .rgmii_rxc_2                 (1'b0),
    .rgmii_rxc_3                 (1'b0),
    .rgmii_rxc_4                 (1'b0),
    .rgmii_txd_1                 (p1.txd),
    .rgmii_txd_2                 (p2.txd),
    .rgmii_txd_3                 (p3.txd),
    .rgmii_txd_4                 (p4.txd),
    .rgmii_tx_ctl_1              (p1.tx_ctl),
    .rgmii_tx_ctl_2              (p2.tx_ctl),
    .rgmii_tx_ctl_3              (p3.tx_ctl),
    .rgmii_tx_ctl_4              (p4.tx_ctl),
    .rgmii_txc_1                 (txc1),
    .rgmii_txc_2                 (txc2),
    .rgmii_txc_3                 (txc3),
    .rgmii_txc_4                 (txc4),
    .mdc                         (mdc),
    .mdio                        (mdio),
    .phy_rstn                    (phy_rstn),
    .dma_0_pci_exp_0_rxp_pin     (1'b0),
    .dma_0_pci_exp_0_rxn_pin     (1'b1),
    .dma_0_pci_exp_1_rxp_pin     (1'b0),
    .dma_0_pci_exp_1_rxn_pin     (1'b1),
    .dma_0_pci_exp_2_rxp_pin     (1'b0),
    .dma_0_pci_exp_2_rxn_pin     (1'b1),
    .dma_0_pci_exp_3_rxp_pin     (1'b0),
    .dma_0_pci_exp_3_rxn_pin     (1'b1),
    .dma_0_pci_exp_0_txp_pin     (txp[0]),
    .dma_0_pci_exp_0_txn_pin     (txn[0]),
    .dma_0_pci_exp_1_txp_pin     (txp[1]),
    .dma_0_pci_exp_1_txn_pin     (txn[1]),
    .dma_0_pci_exp_2_txp_pin     (txp[2]),
    .dma_0_pci_exp_2_txn_pin     (txn[2]),
    .dma_0_pci_exp_3_txp_pin     (txp[3]),
    .dma_0_pci_exp_3_txn_pin     (txn[3]),
    .dma_0_pcie_clk_p_pin        (1'b0),
    .dma_0_pcie_clk_n_pin        (1'b1),
    .util_ds_buf_0_IBUF_DS_P_pin (1'b0)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({uart_tx, mdc, mdio, phy_rstn} !== 7'b1_0_1_0000) begin
      errors++; $display("FAIL reset_misc got=%b exp=%b", {uart_tx, mdc, mdio, phy_rstn}, 7'b1_0_1_0000);
    end
    checks++;
    if ({tx4, tx3, tx2, tx1, txc_all} !== 24'h0) begin
      errors++; $display("FAIL reset_tx got=%h exp=0", {tx4, tx3, tx2, tx1, txc_all});
    end
    checks++;
    if (pcie_tx !== 8'b0000_1111) begin
      errors++; $display("FAIL reset_pcie got=%b exp=00001111", pcie_tx);
    end
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (phy_rstn !== 4'b0000) begin
        errors++; $display("FAIL phy_hold i=%0d got=%b exp=0000", i, phy_rstn);
      end
      checks++;
      if ({tx4, tx3, tx2, tx1} !== 20'h0) begin
        errors++; $display("FAIL seq_tx_idle i=%0d got=%h exp=0", i, {tx4, tx3, tx2, tx1});
      end
    end
    @(negedge clk);
    checks++;
    if (phy_rstn !== 4'b1111) begin
      errors++; $display("FAIL phy_release got=%b exp=1111", phy_rstn);
    end
  endtask

  task automatic test_forward();
    logic [4:0] exp;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp = (c >= 3 && c <= 10) ? {1'b1, 4'(c - 2)} : 5'h0;
      checks++;
      if (tx2 !== exp) begin
        errors++; $display("FAIL fwd_tx2 c=%0d got=%h exp=%h", c, tx2, exp);
      end
      checks++;
      if ({tx4, tx3, tx1} !== 15'h0) begin
        errors++; $display("FAIL fwd_others c=%0d got=%h exp=0", c, {tx4, tx3, tx1});
      end
      if (c <= 8) begin
        p1.rx_ctl = 1'b1; p1.rxd = 4'(c);
      end else begin
        p1.rx_ctl = 1'b0; p1.rxd = 4'h0;
      end
    end
  endtask

  task automatic test_frame_at_enable();
    logic [4:0] exp;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      p3.rx_ctl = 1'b1; p3.rxd = 4'(c + 3);
      @(negedge clk);
      checks++;
      if (tx4 !== 5'h0) begin
        errors++; $display("FAIL late_frame_tx4 c=%0d got=%h exp=0", c, tx4);
      end
    end
    p3.rx_ctl = 1'b0; p3.rxd = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (phy_rstn !== 4'b1111 || tx4 !== 5'h0) begin
      errors++; $display("FAIL late_frame_end got=%b/%h exp=1111/00", phy_rstn, tx4);
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp = (c >= 3 && c <= 6) ? {1'b1, 4'(c + 7)} : 5'h0;
      checks++;
      if (tx4 !== exp) begin
        errors++; $display("FAIL next_frame_tx4 c=%0d got=%h exp=%h", c, tx4, exp);
      end
      if (c <= 4) begin
        p3.rx_ctl = 1'b1; p3.rxd = 4'(c + 9);
      end else begin
        p3.rx_ctl = 1'b0; p3.rxd = 4'h0;
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    p1.rx_ctl = 1'b1; p1.rxd = 4'h5;
    repeat (4) @(negedge clk);
    checks++;
    if (tx2 !== 5'h15) begin
      errors++; $display("FAIL mid_active got=%h exp=15", tx2);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx4, tx3, tx2, tx1} !== 20'h0) begin
      errors++; $display("FAIL mid_reset_tx got=%h exp=0", {tx4, tx3, tx2, tx1});
    end
    checks++;
    if ({phy_rstn, mdc, txc_all, uart_tx, mdio} !== 11'b0000_0_0000_1_1) begin
      errors++; $display("FAIL mid_reset_misc got=%b exp=00000000011", {phy_rstn, mdc, txc_all, uart_tx, mdio});
    end
    reset = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      @(negedge clk);
      checks++;
      if (tx2 !== 5'h0) begin
        errors++; $display("FAIL mid_discard i=%0d got=%h exp=0", i, tx2);
      end
      checks++;
      if (phy_rstn !== ((i >= 17) ? 4'b1111 : 4'b0000)) begin
        errors++; $display("FAIL mid_phy_seq i=%0d got=%b exp=%b", i, phy_rstn, (i >= 17) ? 4'b1111 : 4'b0000);
      end
      if (i == 20) begin
        p1.rx_ctl = 1'b0; p1.rxd = 4'h0;
      end
    end
  endtask

  task automatic test_mdc();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      checks++;
      if (mdc !== (((i / 4) % 2) == 1)) begin
        errors++; $display("FAIL mdc i=%0d got=%b exp=%b", i, mdc, ((i / 4) % 2) == 1);
      end
      checks++;
      if (mdio !== 1'b1) begin
        errors++; $display("FAIL mdio i=%0d got=%b exp=1", i, mdio);
      end
      checks++;
      if (txc_all !== {4{(i % 2) == 1}}) begin
        errors++; $display("FAIL txc i=%0d got=%b exp=%b", i, txc_all, {4{(i % 2) == 1}});
      end
    end
  endtask

  task automatic test_uart_pcie();
    logic exp;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
      checks++;
      if (uart_tx !== exp) begin
        errors++; $display("FAIL uart_echo c=%0d got=%b exp=%b", c, uart_tx, exp);
      end
      checks++;
      if (pcie_tx !== 8'b0000_1111) begin
        errors++; $display("FAIL pcie_tie c=%0d got=%b exp=00001111", c, pcie_tx);
      end
      if (c == 1) uart_rx = 1'b0;
      if (c == 5) uart_rx = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    p1.rxd = 4'h0; p1.rx_ctl = 1'b0;
    p2.rxd = 4'h0; p2.rx_ctl = 1'b0;
    p3.rxd = 4'h0; p3.rx_ctl = 1'b0;
    p4.rxd = 4'h0; p4.rx_ctl = 1'b0;
    test_reset();
    test_forward();
    test_frame_at_enable();
    test_mid_frame_reset();
    test_mdc();
    test_uart_pcie();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
